// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; push is accepted when not full or when a pop
// frees a slot in the same cycle. Empty FIFO reads back as zero.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [PW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, rp_q;
  logic [PW:0]      level_q, level_d;
  logic             do_pop, do_push;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rp_q];
  assign level_o = level_q;

  // Occupancy next-state: simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage write; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM, sticky error flags,
// and a small byte FIFO presented as a valid/ready stream.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic          clr_err,
  output logic          frame_err,
  output logic          overrun,
  output logic          busy,
  output logic [LW-1:0] level
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;

  logic [1:0]  sync_q;
  logic        rx_s;
  rx_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shreg_q;
  logic        frame_err_q, overrun_q;
  logic        tick, push, pop, ferr_ev, ovr_ev, full, empty;

  assign rx_s    = sync_q[1];
  assign tick    = (cnt_q == '0);
  assign push    = (state_q == STOP) & tick & rx_s;
  assign ferr_ev = (state_q == STOP) & tick & ~rx_s;
  assign pop     = m_valid & m_ready;
  assign ovr_ev  = push & full & ~pop;
  assign m_valid = ~empty;
  assign busy    = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  // Receive FSM: half-bit delay to the start-bit centre, then one bit period per sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (!rx_s) begin
          state_q <= START;
          cnt_q   <= CW'(H - 1);
        end
        START: if (tick) begin
          cnt_q <= CW'(CLKS_PER_BIT - 1);
          idx_q <= '0;
          state_q <= rx_s ? IDLE : DATA;
        end else cnt_q <= cnt_q - 1'b1;
        DATA: if (tick) begin
          cnt_q   <= CW'(CLKS_PER_BIT - 1);
          shreg_q <= {rx_s, shreg_q[7:1]};
          if (idx_q == 3'(DATA_BITS - 1)) state_q <= STOP;
          else                            idx_q   <= idx_q + 1'b1;
        end else cnt_q <= cnt_q - 1'b1;
        STOP: if (tick) begin
          cnt_q   <= CW'(CLKS_PER_BIT - 1);
          state_q <= rx_s ? IDLE : BREAK;
        end else cnt_q <= cnt_q - 1'b1;
        BREAK: if (rx_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_ev | (frame_err_q & ~clr_err);
      overrun_q   <= ovr_ev  | (overrun_q   & ~clr_err);
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (shreg_q),
    .rdata_o (m_data),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: frames are driven on rx, expected bytes go into a queue,
// and a negedge monitor checks every popped byte against it.
module tb_uart_rx_fifo;

  localparam int C = 8;

  logic       clk, rst_n, rx, m_ready, clr_err;
  logic [7:0] m_data;
  logic       m_valid, frame_err, overrun, busy;
  logic [2:0] level;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb [$];

  uart_rx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .clr_err(clr_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0; wait_cyc(C);
    for (int i = 0; i < 8; i++) begin rx = b[i]; wait_cyc(C); end
    rx = stop; wait_cyc(C);
  endtask

  task automatic pop_n(input int n);
    m_ready = 1'b1; wait_cyc(n); m_ready = 1'b0;
  endtask

  // Monitor: every accepted pop is compared with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL pop_unexpected: got %0h expected none", m_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("pop_data", {24'd0, m_data}, {24'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clk = 0; rx = 1; rst_n = 0; m_ready = 0; clr_err = 0;
    wait_cyc(3);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    rst_n = 1; wait_cyc(2);

    // Single byte with exact visibility cycle t0+77
    sb.push_back(8'hA5);
    fork
      send(8'hA5, 1'b1);
      begin
        repeat (78) @(posedge clk);
        @(negedge clk); chk("a5_valid_early", m_valid, 0);
        @(negedge clk); chk("a5_valid_rise", m_valid, 1);
        chk("a5_data", m_data, 8'hA5);
        chk("a5_level", level, 1);
      end
    join
    pop_n(1);
    chk("a5_valid_after_pop", m_valid, 0);
    chk("a5_level_after_pop", level, 0);

    // Back-to-back frames fill the FIFO
    sb.push_back(8'h00); send(8'h00, 1'b1);
    sb.push_back(8'hFF); send(8'hFF, 1'b1);
    sb.push_back(8'h3C); send(8'h3C, 1'b1);
    sb.push_back(8'h81); send(8'h81, 1'b1);
    chk("b2b_level", level, 4);
    chk("b2b_ovr", overrun, 0);
    chk("b2b_ferr", frame_err, 0);

    // Overrun: fifth byte dropped, contents unchanged
    fork
      send(8'h55, 1'b1);
      begin
        repeat (78) @(posedge clk);
        @(negedge clk); chk("ovr_early", overrun, 0);
        @(negedge clk); chk("ovr_set", overrun, 1);
      end
    join
    chk("ovr_level", level, 4);
    chk("ovr_head", m_data, 8'h00);
    clr_err = 1; wait_cyc(1); clr_err = 0;
    chk("ovr_cleared", overrun, 0);

    // Same-cycle pop makes room for the push
    sb.push_back(8'hC3);
    fork
      send(8'hC3, 1'b1);
      begin repeat (78) @(posedge clk); #1; pop_n(1); end
    join
    chk("same_cycle_ovr", overrun, 0);
    chk("same_cycle_level", level, 4);
    pop_n(4);
    chk("drain_level", level, 0);
    chk("drain_sb_empty", sb.size(), 0);

    // Framing error followed by a held-low break
    send(8'h12, 1'b0);
    wait_cyc(40);
    chk("brk_busy", busy, 1);
    chk("brk_ferr", frame_err, 1);
    chk("brk_level", level, 0);
    rx = 1; wait_cyc(1);
    chk("brk_busy_sync", busy, 1);
    wait_cyc(3);
    chk("brk_idle", busy, 0);
    sb.push_back(8'h34); send(8'h34, 1'b1);
    chk("post_brk_level", level, 1);
    chk("post_brk_data", m_data, 8'h34);

    // Two-cycle glitch: back to IDLE after the start-bit check, nothing pushed
    rx = 0; wait_cyc(2); rx = 1;
    wait_cyc(1); chk("glitch_busy", busy, 1);
    wait_cyc(3); chk("glitch_busy_chk", busy, 1);
    wait_cyc(1); chk("glitch_idle", busy, 0);
    wait_cyc(8); chk("glitch_level", level, 1);

    // Reset mid-frame, held until the line is idle again
    fork
      send(8'h99, 1'b1);
      begin
        wait_cyc(36);
        rst_n = 0; #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_ferr", frame_err, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_level", level, 0);
        sb.delete();
      end
    join
    rst_n = 1; wait_cyc(2);
    sb.push_back(8'h7E); send(8'h7E, 1'b1);
    chk("rst_7e_level", level, 1);
    pop_n(1);
    chk("final_level", level, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
